// File: rtl/tb_step_sequencer.sv
// Timed stimulus sequencer: walks a table of {dwell, vector} steps and restarts on a failed check.
// Optional SEQ_LOOP_EN: after the final step the run loops back to step 0 until abort.
module tb_step_sequencer #(
    parameter int NUM_STEPS = 13,
    parameter int CNT_W     = 16,
    parameter int OUT_W     = 4,
    parameter int IDX_W     = $clog2(NUM_STEPS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             cond,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [CNT_W-1:0] cfg_dur,
    input  logic [OUT_W-1:0] cfg_vec,
    output logic [OUT_W-1:0] stim,
    output logic [IDX_W-1:0] step_idx,
    output logic             busy,
    output logic             done,
    output logic             restart
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    localparam logic [IDX_W:0]   LP_NUM  = (IDX_W+1)'(NUM_STEPS);
    localparam logic [IDX_W-1:0] LP_LAST = IDX_W'(NUM_STEPS - 1);
    localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [OUT_W-1:0] r_stim;
    logic             r_busy;
    logic             r_done;
    logic             r_restart;

    logic [CNT_W-1:0] r_dur [NUM_STEPS];
    logic [OUT_W-1:0] r_vec [NUM_STEPS];

    logic                 w_cfg_open;
    logic                 w_wr_ok;
    logic [NUM_STEPS-1:0] w_entry_we;
    logic [CNT_W-1:0]     w_dur_cur;
    logic [IDX_W-1:0]     w_idx_inc;
    logic                 w_last;

`ifdef SEQ_LOOP_EN
    assign w_cfg_open = (r_state == ST_IDLE);
`else
    assign w_cfg_open = (r_state == ST_IDLE) || (r_state == ST_DONE);
`endif

    assign w_wr_ok = cfg_we && w_cfg_open && ({1'b0, cfg_addr} < LP_NUM);

    for (genvar gi = 0; gi < NUM_STEPS; gi++) begin : g_entry_we
        assign w_entry_we[gi] = w_wr_ok && (cfg_addr == IDX_W'(gi));
    end

    // Table is cleared by reset, so it lives in registers rather than block RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_STEPS; i++) begin
            if (reset) begin
                r_dur[i] <= '0;
                r_vec[i] <= '0;
            end else if (w_entry_we[i]) begin
                r_dur[i] <= cfg_dur;
                r_vec[i] <= cfg_vec;
            end
        end
    end

    assign w_dur_cur = r_dur[r_idx];
    assign w_idx_inc = r_idx + 1'b1;
    // A zero duration behaves as a single-cycle dwell.
    assign w_last    = (w_dur_cur <= LP_ONE) || (r_cnt == w_dur_cur - LP_ONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_stim    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_restart <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_restart <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_stim  <= r_vec[0];
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_stim  <= '0;
                    end else if (w_last) begin
                        r_cnt <= '0;
                        if (cond) begin
                            r_idx     <= '0;
                            r_stim    <= r_vec[0];
                            r_restart <= 1'b1;
                        end else if (r_idx != LP_LAST) begin
                            r_idx  <= w_idx_inc;
                            r_stim <= r_vec[w_idx_inc];
                        end else begin
`ifdef SEQ_LOOP_EN
                            r_idx  <= '0;
                            r_stim <= r_vec[0];
                            r_done <= 1'b1;
`else
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_stim  <= '0;
                            r_done  <= 1'b1;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + LP_ONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_idx   <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign stim     = r_stim;
    assign step_idx = r_idx;
    assign busy     = r_busy;
    assign done     = r_done;
    assign restart  = r_restart;

endmodule
